// File: rtl/zombie_controller.sv
// zombie_controller: behaviour engine for one zombie slot.
// Spawns in a lane, walks left one pixel per step period, eats while blocked,
// takes damage, plays a timed death and flags reaching the house.
// Optional build macro: ZOM_SPEEDUP_EN (halves the step period once hp is at
// or below half of MAX_HP).
module zombie_controller #(
  parameter logic [9:0] START_X      = 10'd600,
  parameter logic [9:0] ROW0_Y       = 10'd100,
  parameter logic [9:0] ROW_PITCH    = 10'd100,
  parameter int         ROWS         = 5,
  parameter logic [9:0] HOUSE_X      = 10'd40,
  parameter logic [3:0] MAX_HP       = 4'd10,
  parameter int         STEP_FRAMES  = 4,
  parameter int         BITE_FRAMES  = 60,
  parameter int         DYING_FRAMES = 30
) (
  input  logic       MAX10_CLK1_50,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic [2:0] spawn_row,
  input  logic       hit,
  input  logic [3:0] hit_dmg,
  input  logic       blocked,
  output logic [9:0] ZomX,
  output logic [9:0] ZomY,
  output logic       ZomLive,
  output logic       bite,
  output logic       reached_house,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_EAT   = 2'd2,
    S_DYING = 2'd3
  } state_t;

  localparam int         FAST_FRAMES = (STEP_FRAMES / 2 > 0) ? (STEP_FRAMES / 2) : 1;
  localparam logic [7:0] STEP_LAST   = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] FAST_LAST   = 8'(FAST_FRAMES - 1);
  localparam logic [7:0] BITE_LAST   = 8'(BITE_FRAMES - 1);
  localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);
  localparam logic [3:0] ROWS_W      = 4'(ROWS);
  localparam logic [3:0] HALF_HP     = MAX_HP >> 1;

  state_t     r_state, w_state_nxt;
  logic       r_fc_cur, r_fc_prev, w_tick;
  logic [9:0] r_zom_x, w_zom_x;
  logic [9:0] r_zom_y, w_zom_y;
  logic       r_live, w_live;
  logic       r_bite, w_bite;
  logic       r_house, w_house;
  logic [3:0] r_hp, w_hp;
  logic [7:0] r_step_cnt, w_step_cnt;
  logic [7:0] r_bite_cnt, w_bite_cnt;
  logic [7:0] r_dying_cnt, w_dying_cnt;
  logic [7:0] w_period_last;
  logic [9:0] w_spawn_y;
  logic       w_lethal;

  assign w_tick    = r_fc_cur & ~r_fc_prev;
  assign w_spawn_y = ROW0_Y + ROW_PITCH * 10'(spawn_row);
  assign w_lethal  = (hit_dmg >= r_hp);

  assign ZomX          = r_zom_x;
  assign ZomY          = r_zom_y;
  assign ZomLive       = r_live;
  assign bite          = r_bite;
  assign reached_house = r_house;
  assign state         = r_state;

  // Register the frame level and all behaviour state; Reset drops any zombie in flight.
  always_ff @(posedge MAX10_CLK1_50 or posedge Reset) begin
    if (Reset) begin
      r_fc_cur    <= 1'b0;
      r_fc_prev   <= 1'b0;
      r_state     <= S_IDLE;
      r_zom_x     <= 10'd0;
      r_zom_y     <= 10'd0;
      r_live      <= 1'b0;
      r_bite      <= 1'b0;
      r_house     <= 1'b0;
      r_hp        <= 4'd0;
      r_step_cnt  <= 8'd0;
      r_bite_cnt  <= 8'd0;
      r_dying_cnt <= 8'd0;
    end else begin
      r_fc_cur    <= frame_clk;
      r_fc_prev   <= r_fc_cur;
      r_state     <= w_state_nxt;
      r_zom_x     <= w_zom_x;
      r_zom_y     <= w_zom_y;
      r_live      <= w_live;
      r_bite      <= w_bite;
      r_house     <= w_house;
      r_hp        <= w_hp;
      r_step_cnt  <= w_step_cnt;
      r_bite_cnt  <= w_bite_cnt;
      r_dying_cnt <= w_dying_cnt;
    end
  end

  // Next-state and next-output logic; priority within a cycle is hit > house > blocked > step.
  always_comb begin
    w_state_nxt = r_state;
    w_zom_x     = r_zom_x;
    w_zom_y     = r_zom_y;
    w_bite      = 1'b0;
    w_house     = r_house;
    w_hp        = r_hp;
    w_step_cnt  = r_step_cnt;
    w_bite_cnt  = r_bite_cnt;
    w_dying_cnt = r_dying_cnt;

`ifdef ZOM_SPEEDUP_EN
    w_period_last = (r_hp <= HALF_HP) ? FAST_LAST : STEP_LAST;
`else
    w_period_last = STEP_LAST;
`endif

    case (r_state)
      S_IDLE: begin
        if (spawn && ({1'b0, spawn_row} < ROWS_W)) begin
          w_state_nxt = S_WALK;
          w_zom_x     = START_X;
          w_zom_y     = w_spawn_y;
          w_hp        = MAX_HP;
          w_step_cnt  = 8'd0;
          w_bite_cnt  = 8'd0;
          w_dying_cnt = 8'd0;
          w_house     = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WALK: begin
        if (hit) begin
          if (w_lethal) begin
            w_hp        = 4'd0;
            w_dying_cnt = 8'd0;
            w_state_nxt = S_DYING;
          end else begin
            w_hp = r_hp - hit_dmg;
          end
        end else if (r_zom_x <= HOUSE_X) begin
          w_house     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (blocked) begin
          w_bite_cnt  = 8'd0;
          w_state_nxt = S_EAT;
        end else if (w_tick) begin
          // >= lets a freshly shortened period take effect on the very next tick
          if (r_step_cnt >= w_period_last) begin
            w_zom_x    = r_zom_x - 10'd1;
            w_step_cnt = 8'd0;
          end else begin
            w_step_cnt = r_step_cnt + 8'd1;
          end
        end else begin
          w_step_cnt = r_step_cnt;
        end
      end
      S_EAT: begin
        if (hit) begin
          if (w_lethal) begin
            w_hp        = 4'd0;
            w_dying_cnt = 8'd0;
            w_state_nxt = S_DYING;
          end else begin
            w_hp = r_hp - hit_dmg;
          end
        end else if (!blocked) begin
          w_step_cnt  = 8'd0;
          w_state_nxt = S_WALK;
        end else if (w_tick) begin
          if (r_bite_cnt == BITE_LAST) begin
            w_bite     = 1'b1;
            w_bite_cnt = 8'd0;
          end else begin
            w_bite_cnt = r_bite_cnt + 8'd1;
          end
        end else begin
          w_bite_cnt = r_bite_cnt;
        end
      end
      S_DYING: begin
        if (w_tick) begin
          if (r_dying_cnt == DYING_LAST) begin
            w_dying_cnt = 8'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_dying_cnt = r_dying_cnt + 8'd1;
          end
        end else begin
          w_dying_cnt = r_dying_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_live = (w_state_nxt != S_IDLE);
  end

endmodule
